// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the fifo_drain_arb readout scheduler: state encoding,
// header magic and channel-index helpers.
package fifo_drain_pkg;

  localparam int         N_CH      = 4;
  localparam int         CH_W      = 2;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REQ,
    S_PUSH,
    S_HDR
  } state_t;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [N_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_drain_arb_rr_pick4.sv
// Combinational 4-way round-robin search: first asserted req at or after ptr,
// wrapping 3 -> 0.
module rr_pick4
  import fifo_drain_pkg::*;
(
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            hit,
  output logic [CH_W-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    hit = 1'b0;
    idx = ptr;
    // Walk from the farthest candidate back to ptr so the nearest one wins.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req[ptr + CH_W'(k)]) begin
        hit = 1'b1;
        idx = ptr + CH_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// Round-robin Wishbone drain of four receive FIFOs into one channel-tagged
// 32-bit valid/ready stream. Define FIFO_DRAIN_ARB_HDR_EN for a header per burst.
module fifo_drain_arb
  import fifo_drain_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int THRESH    = 1,
  parameter int ACK_TMO   = 15
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic         enable,
  input  logic [3:0]   ch_mask,
  input  logic [63:0]  fifo_cnt,
  output logic [3:0]   m_cyc,
  output logic [3:0]   m_stb,
  input  logic [3:0]   m_ack,
  input  logic [127:0] m_dat,
  output logic [31:0]  out_dat,
  output logic [1:0]   out_ch,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic         busy,
  output logic [3:0]   tmo_err,
  input  logic         err_clr
);

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] ptr;
  logic [7:0]      burst_len;
  logic [7:0]      word_cnt;
  logic [7:0]      tmo_cnt;

  logic [N_CH-1:0] elig;
  logic            pick_hit;
  logic [CH_W-1:0] pick_idx;
  logic [15:0]     pick_cnt;
  logic [7:0]      pick_len;
  logic            last_word;

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = ch_mask[i] && (fifo_cnt[16*i +: 16] >= 16'(THRESH))
                           && (fifo_cnt[16*i +: 16] != 16'd0);
    end
  end

  rr_pick4 u_pick (
    .req (elig),
    .ptr (ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign pick_cnt  = fifo_cnt[{pick_idx, 4'b0000} +: 16];
  assign pick_len  = (pick_cnt >= 16'(MAX_BURST)) ? 8'(MAX_BURST) : pick_cnt[7:0];
  assign last_word = (word_cnt + 8'd1 == burst_len);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state     <= S_IDLE;
      ch        <= '0;
      ptr       <= '0;
      burst_len <= '0;
      word_cnt  <= '0;
      tmo_cnt   <= '0;
      m_cyc     <= '0;
      m_stb     <= '0;
      out_dat   <= '0;
      out_ch    <= '0;
      out_vld   <= 1'b0;
      busy      <= 1'b0;
      tmo_err   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later write to a tmo_err
      // bit in this block overrides the clear, so a same-cycle timeout wins.
      if (err_clr) tmo_err <= '0;

      case (state)
        S_IDLE: if (enable) state <= S_ARB;

        S_ARB: begin
          if (pick_hit) begin
            ch        <= pick_idx;
            burst_len <= pick_len;
            word_cnt  <= '0;
            busy      <= 1'b1;
`ifdef FIFO_DRAIN_ARB_HDR_EN
            out_dat   <= {HDR_MAGIC, 6'b0, pick_idx, 8'b0, pick_len};
            out_ch    <= pick_idx;
            out_vld   <= 1'b1;
            state     <= S_HDR;
`else
            m_cyc     <= ch_onehot(pick_idx);
            m_stb     <= ch_onehot(pick_idx);
            tmo_cnt   <= '0;
            state     <= S_REQ;
`endif
          end else begin
            state <= S_IDLE;
          end
        end

`ifdef FIFO_DRAIN_ARB_HDR_EN
        S_HDR: if (out_rdy) begin
          out_vld <= 1'b0;
          m_cyc   <= ch_onehot(ch);
          m_stb   <= ch_onehot(ch);
          tmo_cnt <= '0;
          state   <= S_REQ;
        end
`endif

        S_REQ: begin
          if (m_ack[ch]) begin
            out_dat <= m_dat[{ch, 5'b00000} +: 32];
            out_ch  <= ch;
            out_vld <= 1'b1;
            m_cyc   <= '0;
            m_stb   <= '0;
            state   <= S_PUSH;
          end else if (tmo_cnt == 8'(ACK_TMO - 1)) begin
            // Slave never answered: abandon the read and the rest of the burst.
            m_cyc       <= '0;
            m_stb       <= '0;
            tmo_err[ch] <= 1'b1;
            ptr         <= ch + 2'd1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        S_PUSH: if (out_rdy) begin
          out_vld  <= 1'b0;
          word_cnt <= word_cnt + 8'd1;
          if (last_word || !enable) begin
            ptr   <= ch + 2'd1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            m_cyc   <= ch_onehot(ch);
            m_stb   <= ch_onehot(ch);
            tmo_cnt <= '0;
            state   <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
